// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin by default; define ALU_ARB_FIXED_PRIO_EN for fixed r0 priority.
module alu_arbiter #(
    parameter int unsigned      DATA_W = 32,
    parameter int unsigned      OP_W   = 4,
    parameter logic [OP_W-1:0]  NOP_OP = '0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [OP_W-1:0]   r0_op,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    output logic              r0_rvalid,
    input  logic              r0_rready,
    output logic [DATA_W-1:0] r0_result,
    output logic              r0_zero,
    output logic              r0_of,

    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [OP_W-1:0]   r1_op,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    output logic              r1_rvalid,
    input  logic              r1_rready,
    output logic [DATA_W-1:0] r1_result,
    output logic              r1_zero,
    output logic              r1_of,

    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_c,
    input  logic              alu_zero,
    input  logic              alu_of
);

    logic              elig0;
    logic              elig1;
    logic              grant0;
    logic              grant1;

    logic              r0_rvalid_q, r0_rvalid_d;
    logic [DATA_W-1:0] r0_result_q, r0_result_d;
    logic              r0_zero_q,   r0_zero_d;
    logic              r0_of_q,     r0_of_d;

    logic              r1_rvalid_q, r1_rvalid_d;
    logic [DATA_W-1:0] r1_result_q, r1_result_d;
    logic              r1_zero_q,   r1_zero_d;
    logic              r1_of_q,     r1_of_d;

    // A requester may be accepted only if its response slot is free or draining now
    always_comb begin
        elig0 = r0_valid & (~r0_rvalid_q | r0_rready);
        elig1 = r1_valid & (~r1_rvalid_q | r1_rready);
    end

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Fixed priority: r0 always wins a tie, so the EX stage never stalls on r1
    always_comb begin
        grant0 = ~rst & elig0;
        grant1 = ~rst & elig1 & ~elig0;
    end
`else
    logic last_q;
    logic last_d;

    // Round-robin: on a tie grant the requester that did not win last time
    always_comb begin
        grant0 = ~rst & elig0 & (~elig1 | last_q);
        grant1 = ~rst & elig1 & (~elig0 | ~last_q);
    end

    // Remember the most recent winner; hold when nobody is granted
    always_comb begin
        last_d = last_q;
        if (grant0) begin
            last_d = 1'b0;
        end else if (grant1) begin
            last_d = 1'b1;
        end
    end

    // Last-winner register; reset to 1 so r0 takes the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign r0_ready = grant0;
    assign r1_ready = grant1;

    // Steer the granted request onto the ALU, idle with a NOP otherwise
    always_comb begin
        alu_op = NOP_OP;
        alu_a  = '0;
        alu_b  = '0;
        unique case (1'b1)
            grant0: begin
                alu_op = r0_op;
                alu_a  = r0_a;
                alu_b  = r0_b;
            end
            grant1: begin
                alu_op = r1_op;
                alu_a  = r1_a;
                alu_b  = r1_b;
            end
            default: ;
        endcase
    end

    // r0 response slot: load on grant, clear valid on drain, else hold
    always_comb begin
        r0_rvalid_d = r0_rvalid_q;
        r0_result_d = r0_result_q;
        r0_zero_d   = r0_zero_q;
        r0_of_d     = r0_of_q;
        if (grant0) begin
            r0_rvalid_d = 1'b1;
            r0_result_d = alu_c;
            r0_zero_d   = alu_zero;
            r0_of_d     = alu_of;
        end else if (r0_rvalid_q & r0_rready) begin
            r0_rvalid_d = 1'b0;
        end
    end

    // r1 response slot: load on grant, clear valid on drain, else hold
    always_comb begin
        r1_rvalid_d = r1_rvalid_q;
        r1_result_d = r1_result_q;
        r1_zero_d   = r1_zero_q;
        r1_of_d     = r1_of_q;
        if (grant1) begin
            r1_rvalid_d = 1'b1;
            r1_result_d = alu_c;
            r1_zero_d   = alu_zero;
            r1_of_d     = alu_of;
        end else if (r1_rvalid_q & r1_rready) begin
            r1_rvalid_d = 1'b0;
        end
    end

    // Response registers; reset discards anything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r0_rvalid_q <= 1'b0;
            r0_result_q <= '0;
            r0_zero_q   <= 1'b0;
            r0_of_q     <= 1'b0;
            r1_rvalid_q <= 1'b0;
            r1_result_q <= '0;
            r1_zero_q   <= 1'b0;
            r1_of_q     <= 1'b0;
        end else begin
            r0_rvalid_q <= r0_rvalid_d;
            r0_result_q <= r0_result_d;
            r0_zero_q   <= r0_zero_d;
            r0_of_q     <= r0_of_d;
            r1_rvalid_q <= r1_rvalid_d;
            r1_result_q <= r1_result_d;
            r1_zero_q   <= r1_zero_d;
            r1_of_q     <= r1_of_d;
        end
    end

    assign r0_rvalid = r0_rvalid_q;
    assign r0_result = r0_result_q;
    assign r0_zero   = r0_zero_q;
    assign r0_of     = r0_of_q;
    assign r1_rvalid = r1_rvalid_q;
    assign r1_result = r1_result_q;
    assign r1_zero   = r1_zero_q;
    assign r1_of     = r1_of_q;

endmodule
